// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch FSM state encoding, instruction width, NOP word and a PC alignment helper.
package if_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_latch.sv
// Fetch-to-decode output register: instruction word, its PC and a valid flag.
// Latency: one cycle from load to outputs.
// Backpressure: stall holds the contents; without stall or load a bubble (valid_out=0) is inserted.
// Ports: clk, reset_n (async active-low); flush, load, stall controls; load_instr/load_pc data in;
//        instr_out, pc_out, valid_out registered outputs.
module if_latch
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               load,
  input  logic               stall,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out
);

  // Priority: flush beats load beats hold. A bubble only clears the valid
  // flag; the stale word and PC stay visible but are marked invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_out <= NOP_WORD;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (load) begin
      instr_out <= load_instr;
      pc_out    <= load_pc;
      valid_out <= 1'b1;
    end else if (!stall) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: walks the PC, requests words from instruction memory, hands them to decode.
// Latency: one cycle from imem_ready to instr_out/valid_out; one instruction per cycle with zero-wait memory.
// Backpressure: stall freezes the output latch; a word arriving under stall parks in a one-entry buffer and fetching pauses.
// Ports: clk, reset_n (async active-low); branch/newPC redirect; stall from decode;
//        imem_req/imem_addr/imem_ready/imem_data memory side; instr_out/pc_out/valid_out to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               branch,
  input  logic [PC_W-1:0]    newPC,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out
);

  fetch_state_t       state_q;
  logic               run_q;        // low during reset and the first cycle after release
  logic [PC_W-1:0]    pc_q;         // address of the next word to fetch
  logic [PC_W-1:0]    drain_addr_q; // address of the abandoned request while draining
  logic [INSTR_W-1:0] buf_instr_q;
  logic [PC_W-1:0]    buf_pc_q;

  logic               lat_flush;
  logic               lat_load;
  logic [INSTR_W-1:0] lat_instr;
  logic [PC_W-1:0]    lat_pc;
  logic               fetching;

  // Requests are suppressed until the first clock edge after reset release,
  // and while a word is parked in the buffer.
  assign imem_req  = run_q && (state_q != S_HOLD);
  // DRAIN must keep presenting the old address until its response returns.
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign fetching  = (state_q == S_FETCH) || (state_q == S_WAIT);

  always_comb begin
    lat_flush = run_q && branch;
    lat_load  = 1'b0;
    lat_instr = imem_data;
    lat_pc    = pc_q;
    if (run_q && !branch && !stall) begin
      if (fetching && imem_ready) begin
        lat_load = 1'b1;
      end else if (state_q == S_HOLD) begin
        lat_load  = 1'b1;
        lat_instr = buf_instr_q;
        lat_pc    = buf_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      run_q        <= 1'b0;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_instr_q  <= NOP_WORD;
      buf_pc_q     <= '0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (branch) begin
            pc_q <= align_pc(newPC);
            // An outstanding request in WAIT cannot be withdrawn; let it drain.
            if ((state_q == S_WAIT) && !imem_ready) begin
              state_q      <= S_DRAIN;
              drain_addr_q <= pc_q;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (imem_ready) begin
            pc_q <= pc_q + PC_STEP;
            if (stall) begin
              buf_instr_q <= imem_data;
              buf_pc_q    <= pc_q;
              state_q     <= S_HOLD;
            end else begin
              state_q <= S_FETCH;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (branch) begin
            pc_q    <= align_pc(newPC);
            state_q <= S_FETCH;
          end else if (!stall) begin
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // The response for the old address is dropped; a further redirect
          // while draining just retargets the PC.
          if (branch) begin
            pc_q <= align_pc(newPC);
          end
          if (imem_ready) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  if_latch u_latch (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (lat_flush),
    .load       (lat_load),
    .stall      (stall),
    .load_instr (lat_instr),
    .load_pc    (lat_pc),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

endmodule
